// File: rtl/alu_issue_arbiter_if.sv
// Handshake bundle between the two issue sources, the shared ALU and writeback
// for alu_issue_arbiter. The arbiter uses the slave modport; its environment uses master.
interface alu_issue_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4
);
  logic              rdy;
  logic              clr;
  logic              req0_valid;
  logic              req1_valid;
  logic [DATA_W-1:0] req0_lv;
  logic [DATA_W-1:0] req0_rv;
  logic [DATA_W-1:0] req1_lv;
  logic [DATA_W-1:0] req1_rv;
  logic [OP_W-1:0]   req0_op;
  logic [OP_W-1:0]   req1_op;
  logic [TAG_W-1:0]  req0_tag;
  logic [TAG_W-1:0]  req1_tag;
  logic              req0_grant;
  logic              req1_grant;
  logic              alu_ready;
  logic [DATA_W-1:0] alu_lv;
  logic [DATA_W-1:0] alu_rv;
  logic [OP_W-1:0]   alu_op;
  logic              alu_success;
  logic [DATA_W-1:0] alu_result;
  logic              res_valid;
  logic              res_src;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_value;
  logic              busy;

  modport slave (
    input  rdy, clr,
    input  req0_valid, req1_valid, req0_lv, req0_rv, req1_lv, req1_rv,
    input  req0_op, req1_op, req0_tag, req1_tag,
    input  alu_success, alu_result,
    output req0_grant, req1_grant,
    output alu_ready, alu_lv, alu_rv, alu_op,
    output res_valid, res_src, res_tag, res_value, busy
  );

  modport master (
    output rdy, clr,
    output req0_valid, req1_valid, req0_lv, req0_rv, req1_lv, req1_rv,
    output req0_op, req1_op, req0_tag, req1_tag,
    output alu_success, alu_result,
    input  req0_grant, req1_grant,
    input  alu_ready, alu_lv, alu_rv, alu_op,
    input  res_valid, res_src, res_tag, res_value, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Two-port (RS / LSB) arbiter sequencing the shared ALU through issue, wait and writeback.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 wins ties.
module alu_issue_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4
) (
  input logic               clk,
  input logic               rst,
  alu_issue_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              src_q, src_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              alu_ready_q, alu_ready_d;
  logic [DATA_W-1:0] alu_lv_q, alu_lv_d;
  logic [DATA_W-1:0] alu_rv_q, alu_rv_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              res_valid_q, res_valid_d;
  logic              res_src_q, res_src_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [DATA_W-1:0] res_value_q, res_value_d;
  logic              busy_q, busy_d;
  logic              win;

  always_comb begin
    win = bus.req1_valid & ~bus.req0_valid;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (bus.req0_valid && bus.req1_valid) win = ~last_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    src_d       = src_q;
    tag_d       = tag_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    alu_ready_d = alu_ready_q;
    alu_lv_d    = alu_lv_q;
    alu_rv_d    = alu_rv_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_src_d   = res_src_q;
    res_tag_d   = res_tag_q;
    res_value_d = res_value_q;
    // A low rdy leaves every register, pulses included, exactly as it was.
    if (bus.rdy) begin
      grant0_d    = 1'b0;
      grant1_d    = 1'b0;
      alu_ready_d = 1'b0;
      res_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!bus.clr && (bus.req0_valid || bus.req1_valid)) begin
            alu_lv_d    = win ? bus.req1_lv  : bus.req0_lv;
            alu_rv_d    = win ? bus.req1_rv  : bus.req0_rv;
            alu_op_d    = win ? bus.req1_op  : bus.req0_op;
            tag_d       = win ? bus.req1_tag : bus.req0_tag;
            src_d       = win;
            last_d      = win;
            grant0_d    = ~win;
            grant1_d    = win;
            alu_ready_d = 1'b1;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (bus.clr) begin
            state_d = bus.alu_success ? IDLE : DRAIN;
          end else if (bus.alu_success) begin
            res_valid_d = 1'b1;
            res_value_d = bus.alu_result;
            res_tag_d   = tag_q;
            res_src_d   = src_q;
            state_d     = IDLE;
          end
        end
        DRAIN: begin
          if (!bus.clr && bus.alu_success) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      src_q       <= 1'b0;
      tag_q       <= '0;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      alu_ready_q <= 1'b0;
      alu_lv_q    <= '0;
      alu_rv_q    <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_src_q   <= 1'b0;
      res_tag_q   <= '0;
      res_value_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      src_q       <= src_d;
      tag_q       <= tag_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      alu_ready_q <= alu_ready_d;
      alu_lv_q    <= alu_lv_d;
      alu_rv_q    <= alu_rv_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      res_tag_q   <= res_tag_d;
      res_value_q <= res_value_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req0_grant = grant0_q;
  assign bus.req1_grant = grant1_q;
  assign bus.alu_ready  = alu_ready_q;
  assign bus.alu_lv     = alu_lv_q;
  assign bus.alu_rv     = alu_rv_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_src    = res_src_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.res_value  = res_value_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level model (queue of in-flight ops).
module tb_alu_issue_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int TW = 4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) bus ();
  alu_issue_arbiter #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit            src;
    logic [TW-1:0] tag;
    logic [DW-1:0] lv;
    logic [DW-1:0] rv;
    logic [OW-1:0] op;
    bit            drop;
  } op_t;

  op_t           inflight[$];
  bit            m_last;
  logic          e_g0, e_g1, e_rdy, e_res, e_src, e_busy;
  logic [DW-1:0] e_lv, e_rv, e_val;
  logic [OW-1:0] e_op;
  logic [TW-1:0] e_tag;
  int            total = 0;
  int            bad = 0;
  int            cnt = 0;

  function automatic logic [DW-1:0] alu_fn(input op_t r);
    return (r.op == '0) ? r.lv + r.rv : (r.lv ^ r.rv) + DW'(r.op);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    op_t r;
    bit  w;
    if (rst) begin
      inflight.delete();
      m_last = 1'b1;
      {e_g0, e_g1, e_rdy, e_res, e_src, e_busy} = '0;
      e_lv = '0; e_rv = '0; e_val = '0; e_op = '0; e_tag = '0;
    end else if (bus.rdy) begin
      {e_g0, e_g1, e_rdy, e_res} = '0;
      if (inflight.size() == 0) begin
        if (!bus.clr && (bus.req0_valid || bus.req1_valid)) begin
          if (bus.req0_valid && bus.req1_valid) w = RR ? !m_last : 1'b0;
          else w = bus.req1_valid;
          r.src  = w;
          r.tag  = w ? bus.req1_tag : bus.req0_tag;
          r.lv   = w ? bus.req1_lv : bus.req0_lv;
          r.rv   = w ? bus.req1_rv : bus.req0_rv;
          r.op   = w ? bus.req1_op : bus.req0_op;
          r.drop = 1'b0;
          inflight.push_back(r);
          m_last = w;
          e_g0 = !w; e_g1 = w; e_rdy = 1'b1;
          e_lv = r.lv; e_rv = r.rv; e_op = r.op;
        end
      end else if (bus.clr) begin
        r = inflight.pop_front();
        if (!(bus.alu_success && !r.drop)) begin
          r.drop = 1'b1;
          inflight.push_front(r);
        end
      end else if (bus.alu_success) begin
        r = inflight.pop_front();
        if (!r.drop) begin
          e_res = 1'b1; e_src = r.src; e_tag = r.tag; e_val = alu_fn(r);
        end
      end
      e_busy = (inflight.size() != 0);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("req0_grant", bus.req0_grant, e_g0);
    chk("req1_grant", bus.req1_grant, e_g1);
    chk("alu_ready", bus.alu_ready, e_rdy);
    chk("alu_lv", bus.alu_lv, e_lv);
    chk("alu_rv", bus.alu_rv, e_rv);
    chk("alu_op", bus.alu_op, e_op);
    chk("res_valid", bus.res_valid, e_res);
    chk("res_src", bus.res_src, e_src);
    chk("res_tag", bus.res_tag, e_tag);
    chk("res_value", bus.res_value, e_val);
    chk("busy", bus.busy, e_busy);
  endtask

  task automatic set_req(input bit p, input bit v, input logic [DW-1:0] lv,
                         input logic [DW-1:0] rv, input logic [OW-1:0] op, input logic [TW-1:0] tag);
    if (p) begin
      bus.req1_valid = v; bus.req1_lv = lv; bus.req1_rv = rv; bus.req1_op = op; bus.req1_tag = tag;
    end else begin
      bus.req0_valid = v; bus.req0_lv = lv; bus.req0_rv = rv; bus.req0_op = op; bus.req0_tag = tag;
    end
  endtask

  task automatic rand_req(input bit p, input bit v);
    set_req(p, v, $urandom, $urandom, OW'($urandom_range(0, 15)), TW'($urandom_range(0, 15)));
  endtask

  // Acts as the ALU: returns the result for whatever op the model says is in flight.
  task automatic alu_ret(input bit s);
    bus.alu_success = s;
    if (inflight.size() != 0) bus.alu_result = alu_fn(inflight[0]);
    else bus.alu_result = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.clr = 1'b0;
    set_req(0, 0, '0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0, '0);
    bus.alu_success = 1'b0; bus.alu_result = '0;
    #1;

    // Reset, single req0 5+7 tag 3, ALU answers after two cycles
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_alu_ready", bus.alu_ready, 0);
    rst = 1'b0;
    set_req(0, 1, 32'd5, 32'd7, 4'd0, 4'd3);
    step();
    chk("t1_grant0", bus.req0_grant, 1);
    chk("t1_alu_ready", bus.alu_ready, 1);
    set_req(0, 0, '0, '0, '0, '0);
    step();
    chk("t1_pulse_width", bus.alu_ready, 0);
    alu_ret(1);
    step();
    alu_ret(0);
    chk("t1_res_valid", bus.res_valid, 1);
    chk("t1_res_tag", bus.res_tag, 3);
    chk("t1_res_src", bus.res_src, 0);
    chk("t1_res_value", bus.res_value, 12);
    step();
    chk("t1_res_pulse", bus.res_valid, 0);

    // Both ports valid continuously for four ops
    rst = 1'b1; step(); rst = 1'b0;
    rand_req(0, 1); rand_req(1, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_grant", {bus.req1_grant, bus.req0_grant}, RR ? ((i % 2) ? 2 : 1) : 1);
      if (e_g0) rand_req(0, 1);
      if (e_g1) rand_req(1, 1);
      alu_ret(1);
      step();
      alu_ret(0);
      chk("rr_src", bus.res_src, RR ? (i % 2) : 0);
    end
    set_req(0, 0, '0, '0, '0, '0); set_req(1, 0, '0, '0, '0, '0);
    step();

    // clr one cycle after issue, ALU answers three cycles later
    rand_req(0, 1);
    step();
    set_req(0, 0, '0, '0, '0, '0);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("t3_busy_drain", bus.busy, 1);
    step(); step();
    alu_ret(1);
    step();
    alu_ret(0);
    chk("t3_no_res", bus.res_valid, 0);
    chk("t3_busy_fall", bus.busy, 0);
    set_req(1, 1, 32'd100, 32'd23, 4'd0, 4'd9);
    step();
    set_req(1, 0, '0, '0, '0, '0);
    chk("t3_grant1", bus.req1_grant, 1);
    alu_ret(1);
    step();
    alu_ret(0);
    chk("t3_res_value", bus.res_value, 123);
    chk("t3_res_src", bus.res_src, 1);

    // clr coincident with alu_success
    rand_req(1, 1);
    step();
    set_req(1, 0, '0, '0, '0, '0);
    step();
    bus.clr = 1'b1; alu_ret(1);
    step();
    bus.clr = 1'b0; alu_ret(0);
    chk("t4_no_res", bus.res_valid, 0);
    chk("t4_idle", bus.busy, 0);

    // rdy low for three cycles in WAIT, with an ignored success in the window
    rand_req(0, 1);
    step();
    set_req(0, 0, '0, '0, '0, '0);
    step();
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_ret(i == 1);
      step();
      chk("t5_frozen_res", bus.res_valid, 0);
      chk("t5_frozen_busy", bus.busy, 1);
    end
    bus.rdy = 1'b1; alu_ret(0);
    step();
    alu_ret(1);
    step();
    alu_ret(0);
    chk("t5_res_valid", bus.res_valid, 1);

    // rst during WAIT, then a stray success
    rand_req(1, 1);
    step();
    set_req(1, 0, '0, '0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_alu_lv", bus.alu_lv, 0);
    alu_ret(1);
    step();
    alu_ret(0);
    chk("t6_no_res", bus.res_valid, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      bus.rdy = ($urandom_range(0, 7) != 0);
      bus.clr = ($urandom_range(0, 15) == 0);
      alu_ret((inflight.size() != 0 && cnt == 0) || ($urandom_range(0, 19) == 0));
      step();
      if (cnt > 0) cnt--;
      if (e_rdy) cnt = $urandom_range(0, 3);
      if (e_g0) rand_req(0, $urandom_range(0, 2) != 0);
      else if (!bus.req0_valid && $urandom_range(0, 2) == 0) rand_req(0, 1);
      if (e_g1) rand_req(1, $urandom_range(0, 2) != 0);
      else if (!bus.req1_valid && $urandom_range(0, 2) == 0) rand_req(1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
